// File: rtl/boot_sequencer.sv
// Bring-up controller: streams host headers/payload into instruction and data BRAM,
// then hands data BRAM to the CPU, pulses its reset and releases the PC stall.
module boot_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  cpu_rst,
  output logic                  rd_enbl,
  output logic                  i_r_enb,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_D = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t                  state_reg, state_next;
  logic                    live_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [8:0]              count_reg, count_next;
  logic [ADDR_WIDTH-1:0]   i_w_addr_reg, i_w_addr_next;
  logic [DATA_WIDTH-1:0]   i_w_dat_reg, i_w_dat_next;
  logic                    i_w_enb_reg, i_w_enb_next;
  logic [ADDR_WIDTH-1:0]   d_w_addr_reg, d_w_addr_next;
  logic [DATA_WIDTH-1:0]   d_w_dat_reg, d_w_dat_next;
  logic                    d_w_enb_reg, d_w_enb_next;

  logic [1:0]              hdr_cmd;
  logic [ADDR_WIDTH-1:0]   hdr_addr;
  logic [8:0]              hdr_count;
  logic                    hdr_bad;
  logic                    xfer;
  logic                    unused_hdr_bits;

  assign hdr_cmd   = s_dat[31:30];
  assign hdr_addr  = s_dat[16 +: ADDR_WIDTH];
  assign hdr_count = s_dat[8:0];
  assign unused_hdr_bits = ^{s_dat[29:26], s_dat[15:9]};

  // Run headers ignore address and count, so only load headers are range-checked.
  assign hdr_bad = (hdr_cmd == 2'b00) ||
                   ((hdr_cmd != 2'b11) &&
                    ((hdr_count == 9'd0) || (hdr_count > 9'd256) || (hdr_addr[1:0] != 2'b00)));

  // live_reg holds s_ready low until the first edge after reset is released.
  assign s_ready = live_reg && ((state_reg == IDLE) || (state_reg == LOAD_I) || (state_reg == LOAD_D));
  assign xfer    = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      live_reg     <= 1'b0;
      addr_reg     <= '0;
      count_reg    <= '0;
      i_w_addr_reg <= '0;
      i_w_dat_reg  <= '0;
      i_w_enb_reg  <= 1'b0;
      d_w_addr_reg <= '0;
      d_w_dat_reg  <= '0;
      d_w_enb_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      live_reg     <= 1'b1;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      i_w_addr_reg <= i_w_addr_next;
      i_w_dat_reg  <= i_w_dat_next;
      i_w_enb_reg  <= i_w_enb_next;
      d_w_addr_reg <= d_w_addr_next;
      d_w_dat_reg  <= d_w_dat_next;
      d_w_enb_reg  <= d_w_enb_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    i_w_addr_next = i_w_addr_reg;
    i_w_dat_next  = i_w_dat_reg;
    i_w_enb_next  = 1'b0;
    d_w_addr_next = d_w_addr_reg;
    d_w_dat_next  = d_w_dat_reg;
    d_w_enb_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (xfer) begin
          if (hdr_bad) begin
            state_next = ERR;
          end else begin
            addr_next  = hdr_addr;
            count_next = hdr_count;
            case (hdr_cmd)
              2'b01:   state_next = LOAD_I;
              2'b10:   state_next = LOAD_D;
              default: state_next = START;
            endcase
          end
        end
      end
      LOAD_I, LOAD_D: begin
        if (xfer) begin
          if (state_reg == LOAD_I) begin
            i_w_enb_next  = 1'b1;
            i_w_addr_next = addr_reg;
            i_w_dat_next  = s_dat;
          end else begin
            d_w_enb_next  = 1'b1;
            d_w_addr_next = addr_reg;
            d_w_dat_next  = s_dat;
          end
          addr_next  = addr_reg + ADDR_WIDTH'(4);
          count_next = count_reg - 9'd1;
          if (count_reg == 9'd1) state_next = IDLE;
        end
      end
      START:   state_next = RUN;
      RUN:     if (halt_req) state_next = IDLE;
      ERR:     state_next = ERR;
      default: state_next = ERR;
    endcase
  end

  assign i_w_addr         = i_w_addr_reg;
  assign i_w_dat          = i_w_dat_reg;
  assign i_w_enb          = i_w_enb_reg;
  assign d_w_addr         = d_w_addr_reg;
  assign d_w_dat          = d_w_dat_reg;
  assign d_w_enb          = d_w_enb_reg;
  assign d_bram_init_done = (state_reg == START) || (state_reg == RUN);
  assign pc_stall         = (state_reg != RUN);
  assign cpu_rst          = (state_reg == START);
  assign rd_enbl          = (state_reg == RUN);
  assign i_r_enb          = (state_reg == RUN);
  assign busy             = (state_reg == LOAD_I) || (state_reg == LOAD_D);
  assign error            = (state_reg == ERR);

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed-vector bench for boot_sequencer: table of per-cycle expectations plus
// hand-written reset, illegal-header and mid-load reset sequences.
module tb_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_dat = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        halt_req = 1'b0;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic        d_bram_init_done, pc_stall, cpu_rst, rd_enbl, i_r_enb, busy, error;

  boot_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .halt_req(halt_req),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .cpu_rst(cpu_rst),
    .rd_enbl(rd_enbl), .i_r_enb(i_r_enb), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Flag bits: {s_ready, i_w_enb, d_w_enb, cpu_rst, pc_stall, d_bram_init_done, rd_enbl, i_r_enb, busy, error}
  localparam logic [9:0] F_IDLE  = 10'b1000100000;
  localparam logic [9:0] F_LOAD  = 10'b1000100010;
  localparam logic [9:0] F_IW    = 10'b0100000000;
  localparam logic [9:0] F_DW    = 10'b0010000000;
  localparam logic [9:0] F_START = 10'b0001110000;
  localparam logic [9:0] F_RUN   = 10'b0000011100;
  localparam logic [9:0] F_ERR   = 10'b0000100001;
  localparam logic [9:0] F_RESET = 10'b0000100000;

  typedef struct {
    logic        v;
    logic [31:0] dat;
    logic        halt;
    logic [9:0]  flags;
    logic [9:0]  waddr;
    logic [31:0] wdat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [9:0] act_flags();
    return {s_ready, i_w_enb, d_w_enb, cpu_rst, pc_stall, d_bram_init_done,
            rd_enbl, i_r_enb, busy, error};
  endfunction

  task automatic add(input logic v, input logic [31:0] dat, input logic halt,
                     input logic [9:0] flags, input logic [9:0] waddr, input logic [31:0] wdat);
    vec_t e;
    e.v = v; e.dat = dat; e.halt = halt; e.flags = flags; e.waddr = waddr; e.wdat = wdat;
    vecs.push_back(e);
  endtask

  task automatic step(input logic v, input logic [31:0] dat, input logic halt);
    s_valid = v; s_dat = dat; halt_req = halt;
    @(posedge clk); #1;
  endtask

  task automatic check_flags(input string name, input logic [9:0] exp);
    logic [9:0] act;
    act = act_flags();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: flags got %b expected %b", name, act, exp);
    end else
      $display("ok   %s: flags %b", name, act);
  endtask

  task automatic check_write(input string name, input logic is_d, input logic [9:0] ea, input logic [31:0] ed);
    logic [9:0]  a;
    logic [31:0] d;
    a = is_d ? d_w_addr : i_w_addr;
    d = is_d ? d_w_dat  : i_w_dat;
    n_cmp++;
    if (a !== ea || d !== ed) begin
      n_bad++;
      $display("FAIL %s: write got %h=%h expected %h=%h", name, a, d, ea, ed);
    end else
      $display("ok   %s: write %h=%h", name, a, d);
  endtask

  task automatic check_reset_vals(input string name);
    logic [93:0] act;
    logic [93:0] exp;
    act = {act_flags(), i_w_addr, i_w_dat, d_w_addr, d_w_dat};
    exp = {F_RESET, 84'd0};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: all outputs at reset values", name);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_dat = '0; halt_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    string nm;
    logic [31:0] bad_hdrs[3];
    bad_hdrs[0] = 32'h0000_0005;
    bad_hdrs[1] = 32'h4000_0000;
    bad_hdrs[2] = 32'h4002_0001;

    // IMEM load of three words, run, stray header ignored in RUN, halt
    add(0, 32'h0,         0, F_IDLE,         10'h000, 32'h0);
    add(1, 32'h4000_0003, 0, F_LOAD,         10'h000, 32'h0);
    add(1, 32'hAAAA_0001, 0, F_LOAD | F_IW,  10'h000, 32'hAAAA_0001);
    add(1, 32'hBBBB_0002, 0, F_LOAD | F_IW,  10'h004, 32'hBBBB_0002);
    add(1, 32'hCCCC_0003, 0, F_IDLE | F_IW,  10'h008, 32'hCCCC_0003);
    add(1, 32'hC000_0000, 0, F_START,        10'h000, 32'h0);
    add(0, 32'h0,         0, F_RUN,          10'h000, 32'h0);
    add(1, 32'h4000_0001, 0, F_RUN,          10'h000, 32'h0);
    add(0, 32'h0,         1, F_IDLE,         10'h000, 32'h0);
    // IMEM load after halt, address wraps past the top of the space
    add(1, 32'h43FC_0002, 0, F_LOAD,         10'h000, 32'h0);
    add(1, 32'h1111_1111, 0, F_LOAD | F_IW,  10'h3FC, 32'h1111_1111);
    add(1, 32'h2222_2222, 0, F_IDLE | F_IW,  10'h000, 32'h2222_2222);
    // DMEM load with s_valid toggling every other cycle
    add(1, 32'h8008_0002, 0, F_LOAD,         10'h000, 32'h0);
    add(0, 32'h0,         0, F_LOAD,         10'h000, 32'h0);
    add(1, 32'h0000_0004, 0, F_LOAD | F_DW,  10'h008, 32'h0000_0004);
    add(0, 32'h0,         0, F_LOAD,         10'h000, 32'h0);
    add(1, 32'h0000_0003, 0, F_IDLE | F_DW,  10'h00C, 32'h0000_0003);
    add(0, 32'h0,         0, F_IDLE,         10'h000, 32'h0);

    @(posedge clk); #1;
    check_reset_vals("reset_state");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].dat, vecs[i].halt);
      nm = $sformatf("vec%0d", i);
      check_flags(nm, vecs[i].flags);
      if (vecs[i].flags[8]) check_write({nm, "_iw"}, 1'b0, vecs[i].waddr, vecs[i].wdat);
      if (vecs[i].flags[7]) check_write({nm, "_dw"}, 1'b1, vecs[i].waddr, vecs[i].wdat);
    end

    // Illegal headers: sticky error until rst
    for (int h = 0; h < 3; h++) begin
      do_reset();
      step(0, 32'h0, 0);
      step(1, bad_hdrs[h], 0);
      check_flags($sformatf("bad%0d_enter", h), F_ERR);
      for (int c = 0; c < 20; c++) begin
        step(c[0], 32'h4000_0001, c[1]);
        check_flags($sformatf("bad%0d_hold%0d", h, c), F_ERR);
      end
    end

    // Reset mid-load after the first of four words
    do_reset();
    step(0, 32'h0, 0);
    step(1, 32'h4010_0004, 0);
    check_flags("midrst_hdr", F_LOAD);
    step(1, 32'h5555_0001, 0);
    check_flags("midrst_w1", F_LOAD | F_IW);
    check_write("midrst_w1_iw", 1'b0, 10'h010, 32'h5555_0001);
    s_dat = 32'h5555_0002;
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst_async");
    @(posedge clk); #1;
    check_reset_vals("midrst_held");
    rst = 1'b0;
    s_valid = 1'b0;
    step(0, 32'h0, 0);
    check_flags("midrst_idle", F_IDLE);
    step(1, 32'h4000_0001, 0);
    check_flags("midrst_newhdr", F_LOAD);
    step(1, 32'h7777_0007, 0);
    check_flags("midrst_neww", F_IDLE | F_IW);
    check_write("midrst_neww_iw", 1'b0, 10'h000, 32'h7777_0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Bring-up controller for the rv32i_sc single-core CPU. It accepts a command/word stream from a host over a valid/ready handshake and writes that stream into the instruction BRAM and the data BRAM. It then hands data-BRAM ownership to the CPU, pulses a CPU reset and releases the PC stall. It replaces the manual load/stall/enable sequencing with one synthesizable block between the host link (UART/AXI bridge) and the core.

## Interface
- `DATA_WIDTH`, 32: BRAM word and host word width.
- `ADDR_WIDTH`, 10: BRAM byte-address width. The address space holds 2^ADDR_WIDTH/4 words.
- `clk` in, 1: single clock. Everything is rising-edge.
- `rst` in, 1: reset. Asynchronous, active-high.
- `s_dat` in, DATA_WIDTH: host word, either a header or a payload word.
- `s_valid` in, 1: `s_dat` is valid.
- `s_ready` out, 1: the sequencer accepts `s_dat` this cycle.
- `halt_req` in, 1: return from RUN to loading. Sampled only in RUN.
- `i_w_addr` out, ADDR_WIDTH: instruction BRAM write address.
- `i_w_dat` out, DATA_WIDTH: instruction BRAM write data.
- `i_w_enb` out, 1: instruction BRAM write enable.
- `d_w_addr` out, ADDR_WIDTH: data BRAM write address.
- `d_w_dat` out, DATA_WIDTH: data BRAM write data.
- `d_w_enb` out, 1: data BRAM write enable.
- `d_bram_init_done` out, 1: data BRAM port mux select. 1 means CPU-driven.
- `pc_stall` out, 1: PC stall.
- `cpu_rst` out, 1: one-cycle synchronous reset pulse to the PC and register file.
- `rd_enbl` out, 1: register-file read enable.
- `i_r_enb` out, 1: instruction BRAM read enable.
- `busy` out, 1: a load is in progress (LOAD_I or LOAD_D).
- `error` out, 1: sticky protocol error.

## Operation
- Header word fields:
  - [31:30] cmd: 01 = load IMEM, 10 = load DMEM, 11 = run, 00 = illegal.
  - [25:16] start byte address.
  - [8:0] word count, valid range 1..256.
  - All other bits are ignored.
- States: IDLE, LOAD_I, LOAD_D, START, RUN, ERR.
- IDLE:
  - `s_ready`=1.
  - An accepted header with cmd 01 loads the address and count registers and goes to LOAD_I. cmd 10 does the same and goes to LOAD_D.
  - cmd 11 goes to START. Its address and count fields are ignored.
  - Go to ERR on any of: cmd 00, count 0, count > 256, or address[1:0] != 00.
- LOAD_I / LOAD_D:
  - `s_ready`=1.
  - Each accepted word is written to the current address of the selected BRAM. The address then increments by 4, modulo 2^ADDR_WIDTH, so it wraps to 0. The count decrements.
  - When the last word is accepted (count == 1), go to IDLE.
  - Words are never re-interpreted as headers mid-load.
- START:
  - `s_ready`=0, `cpu_rst`=1 for exactly one cycle.
  - `d_bram_init_done`=1 is already asserted in this cycle.
  - Next state is always RUN. `halt_req` is ignored in START.
- RUN:
  - `s_ready`=0, `pc_stall`=0, `rd_enbl`=1, `i_r_enb`=1, `d_bram_init_done`=1.
  - `halt_req`=1 goes to IDLE. In that next cycle: `pc_stall`=1, `rd_enbl`=0, `i_r_enb`=0, `d_bram_init_done`=0.
- ERR:
  - `error`=1, `s_ready`=0, `pc_stall`=1.
  - The only exit is `rst`.
- Only one of `i_w_enb` / `d_w_enb` may be high in any cycle. Neither is ever high while `d_bram_init_done`=1.

## Timing
- Reset values:
  - `s_ready`=0, `pc_stall`=1, `d_bram_init_done`=0.
  - `cpu_rst`, `rd_enbl`, `i_r_enb`, `busy`, `error` = 0.
  - All write enables = 0. All write addresses and data = 0.
  - State = IDLE.
- `s_ready` is 1 from the first clock edge after `rst` deasserts.
- Handshake:
  - A transfer happens on a rising edge with `s_valid`&&`s_ready`.
  - The host holds `s_dat` stable while `s_valid`=1 and `s_ready`=0.
  - Back-to-back transfers run at one word per cycle with no bubbles, including header to first payload and last payload to next header.
- Write latency: one cycle. The word accepted at edge N drives `*_w_addr`/`*_w_dat`/`*_w_enb`=1 during cycle N+1, registered. `*_w_enb` is low in every cycle that follows no transfer.
- `busy` is 1 exactly while in LOAD_I or LOAD_D. It falls on the edge that accepts the last word.
- Sequence from the run header (accepted at edge N):
  - Cycle N+1: START, `cpu_rst`=1.
  - Cycle N+2: `pc_stall`=0 and the CPU executes from PC 0.
- Reset mid-load: the load is abandoned. Words already written stay in BRAM. No partial write enable is emitted after `rst` rises.

## Test plan
- Load IMEM at 0x000 with 3 words, then run: the header 0x4000_0003 and words A,B,C give `i_w_enb` pulses at addresses 0x000/0x004/0x008 on three consecutive cycles. The run header 0xC000_0000 then gives one `cpu_rst` cycle, and `pc_stall`=0 on the next cycle.
- Load DMEM with `s_valid` toggled every other cycle: the header 0x8008_0002 and words 4,3 give `d_w_enb` only at 0x008=4 and 0x00C=3. `i_w_enb` stays 0 and `busy` clears after the second word.
- Address wrap: the header 0x43FC_0002 writes its first word to 0x3FC and its second to 0x000.
- Illegal header: 0x0000_0005, 0x4000_0000 and 0x4002_0001 each set `error`=1, keep `s_ready`=0 for 20 cycles, and keep `pc_stall`=1. Only `rst` clears this.
- Run then halt: after `halt_req`=1 in RUN, the next cycle shows `pc_stall`=1, `d_bram_init_done`=0 and `s_ready`=1. A new IMEM load is then accepted.
- Reset mid-load: `rst` asserted after 1 of 4 words gives all outputs at their reset values in the same cycle, and the next header is accepted normally.
